// File: rtl/if_bpred_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_bpred_if                                            |
// | Description : Fetch-stage bus: instruction memory, decode-facing     |
// |               fetch registers, branch resolution and statistics.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface if_bpred_if;
  logic        FREEZE;
  logic [31:0] Instr_Address_OUT;
  logic [31:0] Instr_Mem_IN;
  logic [31:0] Instr1_OUT;
  logic [31:0] Instr1_PC_OUT;
  logic [31:0] Instr1_PC_Plus4_OUT;
  logic        isBranch_IN;
  logic        isTaken_IN;
  logic [31:0] Alt_PC_OUT_ID_IN;
  logic        Request_Alt_PC_IN;
  logic [31:0] Alt_PC_IN;
  logic        Mispredict_OUT;
  logic [31:0] Branch_Count_OUT;
  logic [31:0] Mispredict_Count_OUT;

  // Fetch stage side
  modport master (
    input  FREEZE, Instr_Mem_IN, isBranch_IN, isTaken_IN, Alt_PC_OUT_ID_IN,
           Request_Alt_PC_IN, Alt_PC_IN,
    output Instr_Address_OUT, Instr1_OUT, Instr1_PC_OUT, Instr1_PC_Plus4_OUT,
           Mispredict_OUT, Branch_Count_OUT, Mispredict_Count_OUT
  );

  // Memory / decode side
  modport slave (
    output FREEZE, Instr_Mem_IN, isBranch_IN, isTaken_IN, Alt_PC_OUT_ID_IN,
           Request_Alt_PC_IN, Alt_PC_IN,
    input  Instr_Address_OUT, Instr1_OUT, Instr1_PC_OUT, Instr1_PC_Plus4_OUT,
           Mispredict_OUT, Branch_Count_OUT, Mispredict_Count_OUT
  );
endinterface
`default_nettype wire

// File: rtl/if_bpred.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_bpred                                               |
// | Description : Instruction fetch with direct-mapped BTB and 2-bit     |
// |               saturating predictors; one-bubble squash on mispredict.|
// |               Define BPRED_EN to build the BTB; otherwise every      |
// |               fetch is predicted not-taken.                          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module if_bpred #(
  parameter logic [31:0] RESET_PC     = 32'hBFC00000,
  parameter int unsigned BTB_IDX_BITS = 4
) (
  input  wire logic    CLK,
  input  wire logic    RESET,
  if_bpred_if.master   bus
);
  localparam int unsigned c_NUM_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int unsigned c_TAG_W       = 32 - BTB_IDX_BITS - 2;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_instr_pc4;
  // prediction for the word in decode (d) and for the one before it (c)
  logic        r_pt_d;
  logic [31:0] r_ptgt_d;
  logic        r_pt_c;
  logic [31:0] r_ptgt_c;
  logic [31:0] r_pc_c;
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  logic        w_run;
  logic        w_pt_f;
  logic [31:0] w_ptgt_f;
  logic        w_mispredict;
  logic [31:0] w_next_pc;

  assign w_run = !bus.FREEZE;

`ifdef BPRED_EN
  logic [c_NUM_ENTRIES-1:0] r_valid;
  logic [c_TAG_W-1:0]       r_tag [c_NUM_ENTRIES];
  logic [31:0]              r_tgt [c_NUM_ENTRIES];
  logic [1:0]               r_ctr [c_NUM_ENTRIES];

  logic [BTB_IDX_BITS-1:0]  w_fidx;
  logic [BTB_IDX_BITS-1:0]  w_didx;
  logic [c_TAG_W-1:0]       w_dtag;
  logic                     w_dhit;
  logic [1:0]               w_dctr;

  assign w_fidx   = r_pc[BTB_IDX_BITS+1:2];
  assign w_didx   = r_instr_pc[BTB_IDX_BITS+1:2];
  assign w_dtag   = r_instr_pc[31:BTB_IDX_BITS+2];
  assign w_pt_f   = r_valid[w_fidx] && (r_tag[w_fidx] == r_pc[31:BTB_IDX_BITS+2])
                    && r_ctr[w_fidx][1];
  assign w_ptgt_f = r_tgt[w_fidx];
  assign w_dhit   = r_valid[w_didx] && (r_tag[w_didx] == w_dtag);
  assign w_dctr   = r_ctr[w_didx];

  // Train the entry of the instruction in decode; lookups this cycle see old contents
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      for (int i = 0; i < c_NUM_ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_ctr[i] <= 2'b01;
      end
    end else if (w_run && bus.isBranch_IN) begin
      if (w_dhit) begin
        if (bus.isTaken_IN) begin
          r_tgt[w_didx] <= bus.Alt_PC_OUT_ID_IN;
          if (w_dctr != 2'b11) r_ctr[w_didx] <= w_dctr + 2'd1;
        end else if (w_dctr != 2'b00) begin
          r_ctr[w_didx] <= w_dctr - 2'd1;
        end
      end else if (bus.isTaken_IN) begin
        r_valid[w_didx] <= 1'b1;
        r_tag[w_didx]   <= w_dtag;
        r_tgt[w_didx]   <= bus.Alt_PC_OUT_ID_IN;
        r_ctr[w_didx]   <= 2'b10;
      end
    end
  end
`else
  logic w_unused_dec;

  assign w_pt_f       = 1'b0;
  assign w_ptgt_f     = '0;
  assign w_unused_dec = ^{bus.isTaken_IN, bus.Alt_PC_OUT_ID_IN};
`endif

  // Check the prediction of the previous decode instruction against its resolution
  assign w_mispredict = RESET && w_run &&
                        ((bus.Request_Alt_PC_IN != r_pt_c) ||
                         (bus.Request_Alt_PC_IN && r_pt_c && (bus.Alt_PC_IN != r_ptgt_c)));

  // Next fetch PC: correction first, then a predicted redirect after its delay slot
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (w_mispredict) begin
      w_next_pc = bus.Request_Alt_PC_IN ? bus.Alt_PC_IN : (r_pc_c + 32'd8);
    end else if (r_pt_d) begin
      w_next_pc = r_ptgt_d;
    end
  end

  // PC, fetch registers and prediction stages; a correction squashes the wrong-path word
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_instr_pc4 <= '0;
      r_pt_d      <= 1'b0;
      r_ptgt_d    <= '0;
      r_pt_c      <= 1'b0;
      r_ptgt_c    <= '0;
      r_pc_c      <= '0;
    end else if (w_run) begin
      r_pc        <= w_next_pc;
      r_instr     <= w_mispredict ? 32'd0 : bus.Instr_Mem_IN;
      r_instr_pc  <= r_pc;
      r_instr_pc4 <= r_pc + 32'd4;
      r_pt_d      <= w_pt_f && !w_mispredict;
      r_ptgt_d    <= w_ptgt_f;
      r_pt_c      <= r_pt_d && !w_mispredict;
      r_ptgt_c    <= r_ptgt_d;
      r_pc_c      <= r_instr_pc;
    end
  end

  // Resolved-branch and correction statistics, wrapping
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_run && bus.isBranch_IN) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mispredict) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign bus.Instr_Address_OUT    = r_pc;
  assign bus.Instr1_OUT           = r_instr;
  assign bus.Instr1_PC_OUT        = r_instr_pc;
  assign bus.Instr1_PC_Plus4_OUT  = r_instr_pc4;
  assign bus.Mispredict_OUT       = w_mispredict;
  assign bus.Branch_Count_OUT     = r_branch_cnt;
  assign bus.Mispredict_Count_OUT = r_mispred_cnt;
endmodule
`default_nettype wire

// File: tb/tb_if_bpred.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_if_bpred                                            |
// | Description : Self-checking bench for if_bpred. A program walker     |
// |               produces the expected fetch stream from branch         |
// |               outcomes and an entry-level predictor table.           |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_if_bpred;
  localparam logic [31:0] c_BASE = 32'hBFC00000;

  typedef struct {
    logic [31:0] addr;
    bit          isb;
    bit          tk;
    logic [31:0] alt;
    bit          mis;   // this fetch is on the wrong path and is squashed
  } fetch_t;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  logic CLK;
  logic RESET;
  if_bpred_if bus();

  if_bpred #(.RESET_PC(c_BASE), .BTB_IDX_BITS(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2] ^ 30'h0123_4567, 2'b11};
  endfunction

  // Instruction memory answers in the same cycle
  always_comb bus.Instr_Mem_IN = mem_word(bus.Instr_Address_OUT);

  fetch_t      q[$];
  ent_t        btb[16];
  logic [31:0] br_tgt[logic [31:0]];
  bit          br_always[logic [31:0]];
  bit          dir_tk[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cur_k = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cur_k, obs, exp_v);
    end
  endtask

  task automatic predict(input logic [31:0] pc, output bit ptk, output logic [31:0] ptgt);
    int i;
    i = int'((pc / 4) % 16);
    ptk  = 1'b0;
    ptgt = '0;
`ifdef BPRED_EN
    if (btb[i].valid && btb[i].pc == pc && btb[i].ctr >= 2) begin
      ptk  = 1'b1;
      ptgt = btb[i].tgt;
    end
`endif
  endtask

  task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int i;
    i = int'((pc / 4) % 16);
`ifdef BPRED_EN
    if (btb[i].valid && btb[i].pc == pc) begin
      if (tk) begin
        btb[i].ctr = (btb[i].ctr < 3) ? btb[i].ctr + 1 : 3;
        btb[i].tgt = tgt;
      end else begin
        btb[i].ctr = (btb[i].ctr > 0) ? btb[i].ctr - 1 : 0;
      end
    end else if (tk) begin
      btb[i].valid = 1'b1;
      btb[i].pc    = pc;
      btb[i].tgt   = tgt;
      btb[i].ctr   = 2;
    end
`endif
  endtask

  // Walk the program from reset and list every fetch in cycle order
  task automatic gen(input int n);
    logic [31:0] pc, tgt, ptgt;
    bit          tk, ptk;
    fetch_t      f;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      btb[i].valid = 1'b0;
      btb[i].pc    = '0;
      btb[i].tgt   = '0;
      btb[i].ctr   = 1;
    end
    pc = c_BASE;
    while (q.size() < n) begin
      f.addr = pc; f.isb = 0; f.tk = 0; f.alt = '0; f.mis = 0;
      if (br_tgt.exists(pc)) begin
        predict(pc, ptk, ptgt);
        tgt = (pc == c_BASE + 32'h200) ? c_BASE + 32'h20 * $urandom_range(1, 3) : br_tgt[pc];
        if (br_always.exists(pc)) tk = 1'b1;
        else if (dir_tk.size() > 0) tk = dir_tk.pop_front();
        else tk = 1'($urandom_range(0, 1));
        f.isb = 1; f.tk = tk; f.alt = tgt;
        q.push_back(f);
        train(pc, tk, tgt);
        f.addr = pc + 4; f.isb = 0; f.tk = 0; f.alt = '0;
        q.push_back(f);
        if ((tk != ptk) || (tk && ptk && tgt != ptgt)) begin
          f.addr = ptk ? ptgt : pc + 8;
          f.mis  = 1;
          q.push_back(f);
        end
        pc = tk ? tgt : pc + 8;
      end else begin
        q.push_back(f);
        pc = pc + 4;
      end
    end
  endtask

  task automatic drive_decode(input int k);
    bus.isBranch_IN       = (k > 0) ? q[k-1].isb : 1'b0;
    bus.isTaken_IN        = (k > 0) ? q[k-1].tk  : 1'b0;
    bus.Alt_PC_OUT_ID_IN  = (k > 0) ? q[k-1].alt : 32'd0;
    bus.Request_Alt_PC_IN = (k > 1) ? q[k-2].tk  : 1'b0;
    bus.Alt_PC_IN         = (k > 1) ? q[k-2].alt : 32'd0;
  endtask

  task automatic check_cycle(input int k, input int bc, input int mc, input bit frozen);
    logic [31:0] ei, ep;
    cur_k = k;
    chk("fetch_addr", bus.Instr_Address_OUT, q[k].addr);
    if (k == 0) begin
      chk("instr1_after_reset", bus.Instr1_OUT, 32'd0);
      chk("instr1_pc_after_reset", bus.Instr1_PC_OUT, 32'd0);
    end else if (q[k-1].mis) begin
      chk("instr1_squashed", bus.Instr1_OUT, 32'd0);
    end else begin
      ei = mem_word(q[k-1].addr);
      ep = q[k-1].addr;
      chk("instr1", bus.Instr1_OUT, ei);
      chk("instr1_pc", bus.Instr1_PC_OUT, ep);
      chk("instr1_pc4", bus.Instr1_PC_Plus4_OUT, ep + 32'd4);
    end
    chk("mispredict", {31'd0, bus.Mispredict_OUT}, {31'd0, (q[k].mis && !frozen)});
    chk("branch_cnt", bus.Branch_Count_OUT, bc);
    chk("mispred_cnt", bus.Mispredict_Count_OUT, mc);
  endtask

  // Entered at posedge+1 right after reset release
  task automatic run(input int n);
    int bc, mc, nf;
    bc = 0;
    mc = 0;
    for (int k = 0; k < n; k++) begin
      drive_decode(k);
      if (k == 3 || (k > 20 && $urandom_range(0, 11) == 0)) begin
        nf = (k == 3) ? 3 : int'($urandom_range(1, 3));
        bus.FREEZE = 1'b1;
        repeat (nf) begin
          @(negedge CLK);
          check_cycle(k, bc, mc, 1'b1);
          @(posedge CLK);
          #1;
        end
        bus.FREEZE = 1'b0;
      end
      @(negedge CLK);
      check_cycle(k, bc, mc, 1'b0);
      if (k > 0 && q[k-1].isb) bc++;
      if (q[k].mis) mc++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_addr"}, bus.Instr_Address_OUT, c_BASE);
    chk({tag, "_instr1"}, bus.Instr1_OUT, 32'd0);
    chk({tag, "_pc"}, bus.Instr1_PC_OUT, 32'd0);
    chk({tag, "_mispredict"}, {31'd0, bus.Mispredict_OUT}, 32'd0);
    chk({tag, "_branch_cnt"}, bus.Branch_Count_OUT, 32'd0);
    chk({tag, "_mispred_cnt"}, bus.Mispredict_Count_OUT, 32'd0);
  endtask

  task automatic idle_inputs();
    bus.FREEZE            = 1'b0;
    bus.isBranch_IN       = 1'b0;
    bus.isTaken_IN        = 1'b0;
    bus.Alt_PC_OUT_ID_IN  = 32'd0;
    bus.Request_Alt_PC_IN = 1'b0;
    bus.Alt_PC_IN         = 32'd0;
  endtask

  initial begin
    logic [31:0] a;
    RESET = 1'b0;
    idle_inputs();

    // Program: BEQ at +0x10 -> +0x100, jump at +0x100 -> +0x10,
    // jump at +0x200 with a varying target, random branches in between
    br_tgt[c_BASE + 32'h10]     = c_BASE + 32'h100;
    br_tgt[c_BASE + 32'h100]    = c_BASE + 32'h10;
    br_always[c_BASE + 32'h100] = 1'b1;
    br_tgt[c_BASE + 32'h200]    = c_BASE + 32'h20;
    br_always[c_BASE + 32'h200] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      a = c_BASE + 32'h20 + 32'(16 * k);
      if (a != c_BASE + 32'h100 && $urandom_range(0, 2) == 0)
        br_tgt[a] = c_BASE + 32'(4 * $urandom_range(4, 127));
    end
    // BEQ outcomes: first taken, second taken, then loop exit
    dir_tk = '{1'b1, 1'b1, 1'b0};
    gen(400);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    cur_k = -1;
    check_reset_state("reset");
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    run(400);

    // Asynchronous reset in the middle of a cycle
    #2;
    RESET = 1'b0;
    #1;
    cur_k = -1;
    check_reset_state("async_reset");
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    gen(300);
    run(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
